btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 105 ++++++++++
 tb/tb_btn_debounce.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button debouncer: two-flop synchronizer, four-state qualifier,
// registered level plus one-cycle press and release strobes.
module btn_debounce #(
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CHK_PRESS,
    PRESSED,
    CHK_REL
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic            sync1;
  logic            sync2;
  logic            press_n;
  logic            release_n;
  logic            level_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync2) begin
          state_n = CHK_PRESS;
          cnt_n   = '0;
        end
      end
      CHK_PRESS: begin
        if (!sync2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = PRESSED;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync2) begin
          state_n = CHK_REL;
          cnt_n   = '0;
        end
      end
      CHK_REL: begin
        if (sync2) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
    level_n = (state_n == PRESSED) || (state_n == CHK_REL);
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomized and directed bench for btn_debounce against a run-length
// reference model of the debounce rules.
module tb_btn_debounce;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_in = 1'b0;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  btn_debounce #(.STABLE_CYCLES(S)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: input seen by the qualifier two edges late; level flips
  // after S+1 consecutive edges that see the opposite value.
  logic d1, d2, m_lvl, m_p, m_r;
  int   run;
  int   since, first_p, first_r, np, nr;
  logic last_press;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic b);
    logic seen;
    if (!r) begin
      d1 = 0; d2 = 0; m_lvl = 0; run = 0; m_p = 0; m_r = 0;
    end else begin
      seen = d2;
      m_p = 0;
      m_r = 0;
      run = (seen != m_lvl) ? run + 1 : 0;
      if (run == S + 1) begin
        m_lvl = seen;
        run = 0;
        m_p = seen;
        m_r = !seen;
      end
      d2 = d1;
      d1 = b;
    end
  endtask

  task automatic tick();
    logic r, b;
    r = rst;
    b = btn_in;
    @(posedge clk);
    model_edge(r, b);
    #1;
    since++;
    chk("level", btn_level, m_lvl);
    chk("press", press_pulse, m_p);
    chk("release", release_pulse, m_r);
    if (!r) last_press = 0;
    if (press_pulse) begin
      np++;
      if (first_p < 0) first_p = since;
      chk("alt_press", last_press, 0);
      last_press = 1;
    end
    if (release_pulse) begin
      nr++;
      if (first_r < 0) first_r = since;
      chk("alt_release", last_press, 1);
      last_press = 0;
    end
  endtask

  task automatic run_n(input logic b, input logic r, input int n);
    btn_in = b;
    rst = r;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mark();
    since = 0; first_p = -1; first_r = -1; np = 0; nr = 0;
  endtask

  initial begin
    d1 = 0; d2 = 0; m_lvl = 0; m_p = 0; m_r = 0; run = 0;
    last_press = 0;
    mark();
    #1;

    // Reset with button held
    run_n(1, 0, 3);
    chk("rst_level", btn_level, 0);
    run_n(0, 1, 10);

    // Clean press and hold
    mark();
    run_n(1, 1, 60);
    chk("press_edge", first_p, S + 3);
    chk("press_count", np, 1);
    chk("press_level", btn_level, 1);

    // Clean release
    mark();
    run_n(0, 1, 20);
    chk("rel_edge", first_r, S + 3);
    chk("rel_count", nr, 1);
    chk("rel_level", btn_level, 0);

    // Low glitch of 2 cycles while pressed
    run_n(1, 1, 20);
    mark();
    run_n(0, 1, 2);
    run_n(1, 1, 20);
    chk("glitch_rel", nr, 0);
    chk("glitch_press", np, 0);
    chk("glitch_level", btn_level, 1);
    run_n(0, 1, 20);

    // Bounce: high 3, low 1, then held
    mark();
    run_n(1, 1, 3);
    run_n(0, 1, 1);
    run_n(1, 1, 30);
    chk("bounce_edge", first_p, 4 + S + 3);
    chk("bounce_count", np, 1);
    run_n(0, 1, 20);

    // Reset at edge 5 of a held press
    mark();
    run_n(1, 1, 4);
    run_n(1, 0, 1);
    chk("midrst_pulses", np + nr, 0);
    mark();
    run_n(1, 1, 30);
    chk("midrst_edge", first_p, S + 3);
    chk("midrst_count", np, 1);
    run_n(0, 1, 20);

    // Three press/release cycles of 10 each
    mark();
    for (int k = 0; k < 3; k++) begin
      run_n(1, 1, 10);
      run_n(0, 1, 10);
    end
    chk("tput_press", np, 3);
    chk("tput_release", nr, 3);

    // Random bursts with occasional reset
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 29) == 0)
        run_n($urandom_range(0, 1), 0, $urandom_range(1, 3));
      else
        run_n($urandom_range(0, 1), 1, $urandom_range(1, 12));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
